uart_block_ctrl: RTL and testbench
==================================

UART_BLOCK_CTRL -- requirements
Module: uart_block_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  NBYTES  16  bytes per block (block width = 8*NBYTES)
  RX_TIMEOUT  1000000  idle clock cycles before a partial RX block is discarded
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clock  in  1  single system clock, rising edge
  reset  in  1  asynchronous, active-high reset
  uart_rdy  in  1  UART receiver byte-ready flag
  uart_dout  in  8  UART received byte
  uart_rdy_clr  out  1  clears UART receiver ready flag
  uart_tx_busy  in  1  UART transmitter busy
  uart_wr_en  out  1  UART transmit strobe
  uart_din  out  8  UART byte to transmit
  rx_block  out  8*NBYTES  assembled received block
  rx_block_valid  out  1  rx_block complete and stable
  rx_block_ack  in  1  consumer accepts rx_block
  tx_block  in  8*NBYTES  block to transmit
  tx_block_valid  in  1  tx_block offered
  tx_block_ready  out  1  TX path idle, can accept tx_block
  rx_timeout_err  out  1  one-cycle pulse, partial block discarded

Function
REQ-003 RX and TX paths SHALL be independent FSMs that run concurrently with no shared state.
REQ-004 Byte order SHALL be MSB-first on both paths: the first byte on the wire maps to bits [8*NBYTES-1 : 8*NBYTES-8].
REQ-005 RX FSM states SHALL be RX_COLLECT, RX_CLEAR and RX_FULL.
REQ-006 RX_COLLECT with uart_rdy=1: capture uart_dout into the shift register, increment the byte count, assert uart_rdy_clr for exactly one cycle (registered), and go to RX_CLEAR.
REQ-007 RX_CLEAR SHALL last one cycle and ignore uart_rdy. It SHALL exit to RX_FULL if count==NBYTES, otherwise to RX_COLLECT.
REQ-008 RX_FULL: rx_block_valid=1 and rx_block held constant. uart_rdy is not serviced, so the pending byte stays in the UART. rx_block_ack=1 clears the count to 0 and returns to RX_COLLECT on the next edge.
REQ-009 rx_block_ack while not in RX_FULL SHALL be ignored.
REQ-010 Idle counter:
  - counts cycles in RX_COLLECT while count>0 and uart_rdy=0; resets on every captured byte.
  - on reaching RX_TIMEOUT: count:=0, rx_timeout_err pulses one cycle, shift register contents are don't-care.
REQ-011 TX FSM states SHALL be TX_IDLE, TX_SEND, TX_HOLD and TX_DRAIN.
REQ-012 TX_IDLE: tx_block_ready=1. If tx_block_valid=1, load tx_block into the TX shift register, set the byte index to 0, and go to TX_SEND; tx_block_ready drops in the following cycle.
REQ-013 TX_SEND: when uart_tx_busy=0, assert uart_wr_en for one cycle with uart_din = current top byte, then go to TX_HOLD. uart_din SHALL be stable from the wr_en cycle until the next TX_SEND.
REQ-014 TX_HOLD SHALL last 2 cycles, to cover the UART busy-rise latency. It then goes to TX_DRAIN.
REQ-015 TX_DRAIN: when uart_tx_busy=0, shift the register by 8 and increment the index. If index==NBYTES-1, go to TX_IDLE; otherwise go to TX_SEND.
REQ-016 tx_block_valid and tx_block changes outside TX_IDLE SHALL have no effect.
REQ-017 uart_wr_en SHALL never be asserted while uart_tx_busy=1.
REQ-018 Counter widths SHALL be $clog2(NBYTES+1) for the byte count and $clog2(RX_TIMEOUT+1) for the idle counter. Counters SHALL NOT wrap.

Reset
REQ-019 Asynchronous assertion of reset SHALL immediately force:
  - FSMs to RX_COLLECT and TX_IDLE;
  - counts and shift registers to 0;
  - uart_rdy_clr=0, uart_wr_en=0, uart_din=0, rx_block_valid=0, rx_timeout_err=0;
  - tx_block_ready=1.
REQ-020 Reset mid-block SHALL discard partial RX/TX data; no resumption. After reset release, a byte already latched in the UART (uart_rdy=1) SHALL be accepted as byte 0.

Structure
REQ-021 A shared package SHALL hold the RX/TX state encodings and the default NBYTES and RX_TIMEOUT constants.
REQ-022 The RX path SHALL be one sub-module, uart_rx_assembler. The TX path SHALL stay in the top module.
REQ-023 Outputs uart_rdy_clr, uart_wr_en, uart_din, rx_block_valid and rx_timeout_err SHALL be registered.

Verification
REQ-024 RX block assembly: 16 bytes 0x00..0x0F via uart_rdy/uart_dout -> one uart_rdy_clr pulse per byte; rx_block=0x000102...0F; rx_block_valid held until rx_block_ack.
REQ-025 RX backpressure: 17th byte arrives while in RX_FULL -> not cleared, no uart_rdy_clr. After ack -> captured as byte 0 of the next block.
REQ-026 RX timeout: 5 bytes, then RX_TIMEOUT idle cycles -> one rx_timeout_err pulse. Next 16 bytes -> a correct block with no stale bytes.
REQ-027 TX block send: tx_block=0xA5..(16 bytes) and a UART model with 10-cycle busy -> 16 uart_wr_en pulses carrying 0xA5 first, none during busy; tx_block_ready returns after the last busy falls.
REQ-028 Full-duplex: RX and TX blocks run simultaneously -> both complete correctly with no interference.
REQ-029 Reset mid-TX: reset asserted at byte 7 -> uart_wr_en=0 and tx_block_ready=1 immediately. A new tx_block then transmits from its byte 0.

Source files
------------

// File: rtl/uart_block_ctrl_pkg.sv
// uart_block_ctrl_pkg: shared defaults and RX/TX state encodings for the UART block controller.
package uart_block_ctrl_pkg;
  localparam int NBYTES_DEF = 16;
  localparam int RX_TIMEOUT_DEF = 1000000;
  localparam logic [1:0] RX_COLLECT = 2'd0;
  localparam logic [1:0] RX_CLEAR = 2'd1;
  localparam logic [1:0] RX_FULL = 2'd2;
  localparam logic [1:0] TX_IDLE = 2'd0;
  localparam logic [1:0] TX_SEND = 2'd1;
  localparam logic [1:0] TX_HOLD = 2'd2;
  localparam logic [1:0] TX_DRAIN = 2'd3;
endpackage

// File: rtl/uart_rx_assembler.sv
// uart_rx_assembler: collects UART bytes MSB-first into a block, holds it until acked, drops stale partials.
module uart_rx_assembler
  import uart_block_ctrl_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEF,
  parameter int RX_TIMEOUT = RX_TIMEOUT_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  uart_rdy,
  input  logic [7:0]            uart_dout,
  output logic                  uart_rdy_clr,
  output logic [8*NBYTES-1:0]   rx_block,
  output logic                  rx_block_valid,
  input  logic                  rx_block_ack,
  output logic                  rx_timeout_err
);
  localparam int W = 8 * NBYTES;
  localparam int CW = $clog2(NBYTES + 1);
  localparam int IW = $clog2(RX_TIMEOUT + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(NBYTES);
  localparam logic [IW-1:0] IDLE_LAST = IW'(RX_TIMEOUT - 1);
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idle;
  logic [W-1:0] shreg;
  assign rx_block = shreg;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= RX_COLLECT;
      cnt <= '0;
      idle <= '0;
      shreg <= '0;
      uart_rdy_clr <= 1'b0;
      rx_block_valid <= 1'b0;
      rx_timeout_err <= 1'b0;
    end else begin
      uart_rdy_clr <= 1'b0;
      rx_timeout_err <= 1'b0;
      if (state == RX_COLLECT) begin
        if (uart_rdy) begin
          shreg <= (shreg << 8) | W'(uart_dout);
          cnt <= cnt + CW'(1);
          idle <= '0;
          uart_rdy_clr <= 1'b1;
          state <= RX_CLEAR;
        end else if (cnt != '0) begin
          // the timeout-th idle cycle discards the partial block
          if (idle == IDLE_LAST) begin
            idle <= '0;
            cnt <= '0;
            rx_timeout_err <= 1'b1;
          end else
            idle <= idle + IW'(1);
        end
      end else if (state == RX_CLEAR) begin
        state <= (cnt == FULL_CNT) ? RX_FULL : RX_COLLECT;
        rx_block_valid <= cnt == FULL_CNT;
      end else if (rx_block_ack) begin
        cnt <= '0;
        rx_block_valid <= 1'b0;
        state <= RX_COLLECT;
      end
    end
endmodule

// File: rtl/uart_block_ctrl.sv
// uart_block_ctrl: full-duplex block framing over a byte UART; RX assembly in a sub-module, TX serializer here.
module uart_block_ctrl
  import uart_block_ctrl_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEF,
  parameter int RX_TIMEOUT = RX_TIMEOUT_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  uart_rdy,
  input  logic [7:0]            uart_dout,
  output logic                  uart_rdy_clr,
  input  logic                  uart_tx_busy,
  output logic                  uart_wr_en,
  output logic [7:0]            uart_din,
  output logic [8*NBYTES-1:0]   rx_block,
  output logic                  rx_block_valid,
  input  logic                  rx_block_ack,
  input  logic [8*NBYTES-1:0]   tx_block,
  input  logic                  tx_block_valid,
  output logic                  tx_block_ready,
  output logic                  rx_timeout_err
);
  localparam int W = 8 * NBYTES;
  localparam int CW = $clog2(NBYTES + 1);
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);
  logic [1:0] tx_state;
  logic [CW-1:0] idx;
  logic [W-1:0] tx_sh;
  logic hold;
  uart_rx_assembler #(.NBYTES(NBYTES), .RX_TIMEOUT(RX_TIMEOUT)) u_rx (
    .clock(clock),
    .reset(reset),
    .uart_rdy(uart_rdy),
    .uart_dout(uart_dout),
    .uart_rdy_clr(uart_rdy_clr),
    .rx_block(rx_block),
    .rx_block_valid(rx_block_valid),
    .rx_block_ack(rx_block_ack),
    .rx_timeout_err(rx_timeout_err)
  );
  assign tx_block_ready = tx_state == TX_IDLE;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      tx_state <= TX_IDLE;
      idx <= '0;
      tx_sh <= '0;
      hold <= 1'b0;
      uart_wr_en <= 1'b0;
      uart_din <= '0;
    end else begin
      uart_wr_en <= 1'b0;
      if (tx_state == TX_IDLE) begin
        if (tx_block_valid) begin
          tx_sh <= tx_block;
          idx <= '0;
          tx_state <= TX_SEND;
        end
      end else if (tx_state == TX_SEND) begin
        if (!uart_tx_busy) begin
          uart_wr_en <= 1'b1;
          uart_din <= tx_sh[W-1 -: 8];
          hold <= 1'b0;
          tx_state <= TX_HOLD;
        end
      end else if (tx_state == TX_HOLD) begin
        // two cycles let the UART raise busy before it is trusted again
        hold <= 1'b1;
        if (hold) tx_state <= TX_DRAIN;
      end else if (!uart_tx_busy) begin
        tx_sh <= tx_sh << 8;
        idx <= idx + CW'(1);
        tx_state <= (idx == LAST) ? TX_IDLE : TX_SEND;
      end
    end
endmodule

// File: tb/tb_uart_block_ctrl.sv
// tb_uart_block_ctrl: directed scoreboard bench for uart_block_ctrl with RX/TX UART models.
module tb_uart_block_ctrl;
  localparam int NB = 16;
  localparam int TO = 60;
  localparam int W = 8 * NB;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic uart_rdy = 1'b0;
  logic [7:0] uart_dout = '0;
  logic uart_rdy_clr;
  logic uart_tx_busy;
  logic uart_wr_en;
  logic [7:0] uart_din;
  logic [W-1:0] rx_block;
  logic rx_block_valid;
  logic rx_block_ack = 1'b0;
  logic [W-1:0] tx_block = '0;
  logic tx_block_valid = 1'b0;
  logic tx_block_ready;
  logic rx_timeout_err;
  int n_assert = 0;
  int n_fail = 0;
  int clr_cnt = 0;
  int wr_cnt = 0;
  int err_cnt = 0;
  int busy_cnt = 0;
  logic [W-1:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic rx_seen = 1'b0;
  logic [W-1:0] rx_last = '0;
  uart_block_ctrl #(.NBYTES(NB), .RX_TIMEOUT(TO)) dut (
    .clock(clock),
    .reset(reset),
    .uart_rdy(uart_rdy),
    .uart_dout(uart_dout),
    .uart_rdy_clr(uart_rdy_clr),
    .uart_tx_busy(uart_tx_busy),
    .uart_wr_en(uart_wr_en),
    .uart_din(uart_din),
    .rx_block(rx_block),
    .rx_block_valid(rx_block_valid),
    .rx_block_ack(rx_block_ack),
    .tx_block(tx_block),
    .tx_block_valid(tx_block_valid),
    .tx_block_ready(tx_block_ready),
    .rx_timeout_err(rx_timeout_err)
  );
  always #5 clock = ~clock;
  always @(posedge clock or posedge reset)
    if (reset) busy_cnt <= 0;
    else if (uart_wr_en) busy_cnt <= 10;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  assign uart_tx_busy = busy_cnt != 0;
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [W-1:0] mk(input logic [7:0] s);
    logic [W-1:0] r = '0;
    for (int i = 0; i < NB; i++) r[W-1-8*i -: 8] = s + 8'(i);
    return r;
  endfunction
  always @(negedge clock) begin
    if (uart_rdy_clr) clr_cnt++;
    if (rx_timeout_err) err_cnt++;
    if (uart_wr_en) begin
      wr_cnt++;
      chk("wr_while_busy", W'(uart_tx_busy), '0);
      chk("tx_expected", W'(tx_q.size() != 0), W'(1));
      if (tx_q.size() != 0) chk("tx_byte", W'(uart_din), W'(tx_q.pop_front()));
    end
    if (rx_block_valid && !rx_seen) begin
      rx_seen = 1'b1;
      chk("rx_expected", W'(rx_q.size() != 0), W'(1));
      if (rx_q.size() != 0) begin
        rx_last = rx_q.pop_front();
        chk("rx_block", rx_block, rx_last);
      end
    end
    if (!rx_block_valid) rx_seen = 1'b0;
  end
  task automatic wait_clr();
    bit ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clock);
      if (uart_rdy_clr) begin
        ok = 1'b1;
        break;
      end
    end
    chk("rdy_clr_seen", W'(ok), W'(1));
    uart_rdy = 1'b0;
  endtask
  task automatic rx_byte(input logic [7:0] b);
    uart_dout = b;
    uart_rdy = 1'b1;
    wait_clr();
  endtask
  task automatic rx_send(input logic [7:0] s, input bit noise);
    rx_q.push_back(mk(s));
    for (int i = 0; i < NB; i++) begin
      rx_block_ack = noise && i == 5;
      rx_byte(s + 8'(i));
    end
    rx_block_ack = 1'b0;
  endtask
  task automatic wait_valid();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (rx_block_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("rx_valid_seen", W'(ok), W'(1));
  endtask
  task automatic rx_ack();
    wait_valid();
    rx_block_ack = 1'b1;
    @(negedge clock);
    rx_block_ack = 1'b0;
    chk("valid_after_ack", W'(rx_block_valid), '0);
  endtask
  task automatic wait_ready();
    bit ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      if (tx_block_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("tx_ready_back", W'(ok), W'(1));
    chk("busy_at_ready", W'(uart_tx_busy), '0);
    chk("tx_q_drained", W'(tx_q.size()), '0);
  endtask
  task automatic tx_send(input logic [7:0] s, input bit noise);
    int w0 = wr_cnt;
    for (int i = 0; i < NB; i++) tx_q.push_back(s + 8'(i));
    tx_block = mk(s);
    tx_block_valid = 1'b1;
    @(negedge clock);
    tx_block_valid = 1'b0;
    chk("ready_drop", W'(tx_block_ready), '0);
    if (noise) begin
      repeat (30) @(negedge clock);
      tx_block = mk(8'h00);
      tx_block_valid = 1'b1;
      repeat (3) @(negedge clock);
      tx_block_valid = 1'b0;
    end
    wait_ready();
    chk("tx_wr_count", W'(wr_cnt - w0), W'(NB));
  endtask
  initial begin
    int c0;
    bit ok;
    repeat (2) @(negedge clock);
    chk("rst_rdy_clr", W'(uart_rdy_clr), '0);
    chk("rst_wr_en", W'(uart_wr_en), '0);
    chk("rst_din", W'(uart_din), '0);
    chk("rst_valid", W'(rx_block_valid), '0);
    chk("rst_err", W'(rx_timeout_err), '0);
    chk("rst_ready", W'(tx_block_ready), W'(1));
    reset = 1'b0;
    @(negedge clock);
    c0 = clr_cnt;
    rx_send(8'h00, 1'b0);
    wait_valid();
    chk("rx_clr_count", W'(clr_cnt - c0), W'(NB));
    repeat (20) @(negedge clock);
    chk("rx_valid_held", W'(rx_block_valid), W'(1));
    chk("rx_block_held", rx_block, rx_last);
    uart_dout = 8'h77;
    uart_rdy = 1'b1;
    c0 = clr_cnt;
    repeat (10) @(negedge clock);
    chk("full_no_clr", W'(clr_cnt - c0), '0);
    chk("full_held", rx_block, mk(8'h00));
    rx_q.push_back(mk(8'h77));
    rx_ack();
    wait_clr();
    for (int i = 1; i < NB; i++) begin
      rx_block_ack = i == 5;
      rx_byte(8'h77 + 8'(i));
    end
    rx_block_ack = 1'b0;
    rx_ack();
    c0 = err_cnt;
    for (int i = 0; i < 5; i++) rx_byte(8'h30 + 8'(i));
    repeat (TO - 5) @(negedge clock);
    chk("no_early_timeout", W'(err_cnt - c0), '0);
    repeat (25) @(negedge clock);
    chk("timeout_pulse", W'(err_cnt - c0), W'(1));
    chk("timeout_no_valid", W'(rx_block_valid), '0);
    rx_send(8'h40, 1'b0);
    rx_ack();
    tx_send(8'hA5, 1'b1);
    fork
      rx_send(8'h50, 1'b0);
      tx_send(8'hC0, 1'b0);
    join
    rx_ack();
    c0 = wr_cnt;
    for (int i = 0; i < NB; i++) tx_q.push_back(8'hE0 + 8'(i));
    tx_block = mk(8'hE0);
    tx_block_valid = 1'b1;
    @(negedge clock);
    tx_block_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      #1;
      if (wr_cnt - c0 >= 8) begin
        ok = 1'b1;
        break;
      end
    end
    chk("reach_byte7", W'(ok), W'(1));
    chk("byte7_wr_en", W'(uart_wr_en), W'(1));
    reset = 1'b1;
    #1;
    chk("mid_rst_wr_en", W'(uart_wr_en), '0);
    chk("mid_rst_ready", W'(tx_block_ready), W'(1));
    chk("mid_rst_din", W'(uart_din), '0);
    tx_q.delete();
    uart_dout = 8'h60;
    uart_rdy = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    rx_q.push_back(mk(8'h60));
    wait_clr();
    for (int i = 1; i < NB; i++) rx_byte(8'h60 + 8'(i));
    rx_ack();
    tx_send(8'h10, 1'b0);
    repeat (5) @(negedge clock);
    chk("rx_q_empty", W'(rx_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
